// File: rtl/aes_pkg.sv
// Shared definitions for the AES request arbiter: block width, FSM state
// encodings and the watchdog counter width.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    // Wide enough for any TIMEOUT up to 255.
    localparam int WD_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_KX_START   = 3'd2,
        ST_KX_WAIT    = 3'd3,
        ST_CORE_START = 3'd4,
        ST_CORE_WAIT  = 3'd5,
        ST_RESP       = 3'd6
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr, searching modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [ID_W:0]      sum;
    logic [IDX_W-1:0]   pos;
    logic               found;

    // Walk the requesters starting at ptr and keep the first hit.
    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned, which would infer a latch.
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            pos = sum[IDX_W-1:0];
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                index      = ID_W'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES-128 core and its key-expansion unit among NUM_REQ clients.
// Round-robin grant, single outstanding job, last expanded key cached so a
// repeat key skips expansion, watchdog on both external waits.
module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [AES_BLK_W*NUM_REQ-1:0]   req_data,
    input  logic [AES_BLK_W*NUM_REQ-1:0]   req_key,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [ID_W-1:0]                resp_id,
    output logic [AES_BLK_W-1:0]           resp_data,
    output logic                           resp_err,
    output logic                           kx_start,
    output logic [AES_BLK_W-1:0]           kx_key,
    input  logic                           kx_done,
    output logic                           core_start,
    output logic [AES_BLK_W-1:0]           core_data_in,
    output logic                           core_kx_done,
    input  logic                           core_done,
    input  logic [AES_BLK_W-1:0]           core_data_out,
    input  logic                           flush
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        job_id;
    logic [AES_BLK_W-1:0]   job_data;
    logic [AES_BLK_W-1:0]   job_key;
    logic [AES_BLK_W-1:0]   cache_key;
    logic                   cache_valid;
    logic                   flush_pending;
    logic [WD_W-1:0]        wd;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [ID_W-1:0]        arb_index;
    logic [IDX_W-1:0]       job_sel;
    logic [ID_W-1:0]        next_ptr;
    logic                   wd_expired;

    logic [AES_BLK_W-1:0]   slot_data [NUM_REQ];
    logic [AES_BLK_W-1:0]   slot_key  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign slot_data[g] = req_data[AES_BLK_W*g +: AES_BLK_W];
        assign slot_key[g]  = req_key[AES_BLK_W*g +: AES_BLK_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_index)
    );

    assign job_sel    = job_id[IDX_W-1:0];
    assign next_ptr   = (job_id == ID_W'(NUM_REQ-1)) ? '0 : job_id + ID_W'(1);
    // The waiting state gets exactly TIMEOUT cycles before giving up.
    assign wd_expired = (wd == WD_W'(TIMEOUT-1));

    // Job operands are held in job registers, so both stay constant per job.
    assign kx_key       = job_key;
    assign core_data_in = job_data;
    assign core_kx_done = cache_valid &&
                          (state == ST_CORE_START || state == ST_CORE_WAIT);

    // Job sequencer: grant, optional key expansion, core run, response hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            job_id        <= '0;
            job_data      <= '0;
            job_key       <= '0;
            cache_key     <= '0;
            cache_valid   <= 1'b0;
            flush_pending <= 1'b0;
            wd            <= '0;
            req_ready     <= '0;
            resp_valid    <= 1'b0;
            resp_id       <= '0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            kx_start      <= 1'b0;
            core_start    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments only, so
            // every read in this block sees the value from before the edge.
            req_ready  <= '0;
            kx_start   <= 1'b0;
            core_start <= 1'b0;

            // A flush seen mid-job is remembered and applied in IDLE.
            if (flush && state != ST_IDLE) begin
                flush_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (flush || flush_pending) begin
                        cache_valid   <= 1'b0;
                        flush_pending <= 1'b0;
                    end else if (|req_valid) begin
                        req_ready <= arb_grant;
                        job_id    <= arb_index;
                        state     <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    job_data <= slot_data[job_sel];
                    job_key  <= slot_key[job_sel];
                    rr_ptr   <= next_ptr;
                    if (cache_valid && slot_key[job_sel] == cache_key) begin
                        core_start <= 1'b1;
                        state      <= ST_CORE_START;
                    end else begin
                        kx_start <= 1'b1;
                        state    <= ST_KX_START;
                    end
                end

                ST_KX_START: begin
                    cache_valid <= 1'b0;
                    wd          <= '0;
                    state       <= ST_KX_WAIT;
                end

                ST_KX_WAIT: begin
                    if (kx_done) begin
                        cache_key   <= job_key;
                        cache_valid <= 1'b1;
                        core_start  <= 1'b1;
                        state       <= ST_CORE_START;
                    end else if (wd_expired) begin
                        resp_valid  <= 1'b1;
                        resp_id     <= job_id;
                        resp_data   <= '0;
                        resp_err    <= 1'b1;
                        cache_valid <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end

                ST_CORE_START: begin
                    wd    <= '0;
                    state <= ST_CORE_WAIT;
                end

                ST_CORE_WAIT: begin
                    // A completion in the last allowed cycle still counts.
                    if (core_done) begin
                        resp_valid <= 1'b1;
                        resp_id    <= job_id;
                        resp_data  <= core_data_out;
                        resp_err   <= 1'b0;
                        state      <= ST_RESP;
                    end else if (wd_expired) begin
                        resp_valid  <= 1'b1;
                        resp_id     <= job_id;
                        resp_data   <= '0;
                        resp_err    <= 1'b1;
                        cache_valid <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter. Expected responses are queued when
// a job is issued; a monitor pops and compares each time resp_valid rises.
// Behavioural key-expansion and core models sit on the DUT's core side; the
// core encrypts with whatever key was last expanded.
module tb_aes_req_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int TIMEOUT  = 64;
    localparam int KX_LAT   = 4;
    localparam int CORE_LAT = 12;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] KEY6 = 128'h6666666655555555444444443333333a;
    localparam logic [127:0] KEY7 = 128'h77777777000011112222333344445555;
    localparam logic [127:0] KEYA = 128'hacacacac12121212fefefefe01010101;

    logic                   clk;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [128*NUM_REQ-1:0] req_data;
    logic [128*NUM_REQ-1:0] req_key;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [127:0]           resp_data;
    logic                   resp_err;
    logic                   kx_start;
    logic [127:0]           kx_key;
    logic                   kx_done;
    logic                   core_start;
    logic [127:0]           core_data_in;
    logic                   core_kx_done;
    logic                   core_done;
    logic [127:0]           core_data_out;
    logic                   flush;

    logic [127:0] data_slot [NUM_REQ];
    logic [127:0] key_slot  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_data[128*g +: 128] = data_slot[g];
        assign req_key[128*g +: 128]  = key_slot[g];
    end

    aes_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_key       (req_key),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .kx_start      (kx_start),
        .kx_key        (kx_key),
        .kx_done       (kx_done),
        .core_start    (core_start),
        .core_data_in  (core_data_in),
        .core_kx_done  (core_kx_done),
        .core_done     (core_done),
        .core_data_out (core_data_out),
        .flush         (flush)
    );

    typedef struct {
        logic [1:0]   id;
        logic [127:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    int kx_starts       = 0;
    int kx_start_cycle  = 0;
    int kx_done_cycle   = 0;
    int core_start_cycle = 0;
    int core_done_cycle = 0;
    int resp_cycle      = 0;
    int grant_cycle     = 0;
    logic core_hang     = 1'b0;
    logic [127:0] model_key = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Stand-in cipher: the real FIPS-197 answer for its vector, a keyed mix otherwise.
    function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
    endfunction

    // Key-expansion model: kx_done pulse KX_LAT cycles after kx_start.
    initial begin
        int cnt;
        logic [127:0] lat_key;
        cnt = 0;
        lat_key = '0;
        kx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0;
                kx_done = 1'b0;
            end else begin
                kx_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        kx_done = 1'b1;
                        model_key = lat_key;
                        kx_done_cycle = cycle;
                    end
                end
                if (kx_start) begin
                    cnt = KX_LAT;
                    lat_key = kx_key;
                    kx_starts++;
                    kx_start_cycle = cycle;
                end
            end
        end
    end

    // Core model: done pulse CORE_LAT cycles after core_start, unless hung.
    initial begin
        int cnt;
        logic [127:0] lat_data;
        cnt = 0;
        lat_data = '0;
        core_done = 1'b0;
        core_data_out = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            core_data_out = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
            if (reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        core_done = 1'b1;
                        core_data_out = cipher(lat_data, model_key);
                        core_done_cycle = cycle;
                    end
                end
                if (core_start) begin
                    core_start_cycle = cycle;
                    check_int("core_kx_done_at_start", int'(core_kx_done), 1);
                    lat_data = core_data_in;
                    if (!core_hang) cnt = CORE_LAT;
                end
            end
        end
    end

    // Scoreboard monitor: compare each new response against the queue head.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (resp_valid && !prev) begin
                    resp_cycle = cycle;
                    if (sb.size() == 0) begin
                        check_int("resp_unexpected_queue_depth", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check_int("resp_id", int'(resp_id), int'(e.id));
                        check("resp_data", resp_data, e.data);
                        check_int("resp_err", int'(resp_err), int'(e.err));
                    end
                end
                prev = resp_valid;
            end
        end
    end

    // Grant monitor: req_ready must never show more than one bit.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && req_ready != '0) begin
                check_int("req_ready_onehot", int'($onehot(req_ready)), 1);
                grant_cycle = cycle;
            end
        end
    end

    task automatic push_exp(input logic [1:0] id, input logic [127:0] d,
                            input logic [127:0] k, input logic err);
        exp_t e;
        e.id   = id;
        e.data = err ? '0 : cipher(d, k);
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic start_req(input logic [1:0] id, input logic [127:0] d,
                             input logic [127:0] k, input logic err);
        data_slot[id] = d;
        key_slot[id]  = k;
        req_valid[id] = 1'b1;
        push_exp(id, d, k, err);
    endtask

    task automatic wait_grant(input logic [1:0] id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 300);
        check_int($sformatf("grant_req%0d_in_time", id), int'(n < 300), 1);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_int({tag, "_resp_in_time"}, int'(n < 400), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] id, input logic [127:0] d,
                         input logic [127:0] k, input logic err, input string tag);
        start_req(id, d, k, err);
        wait_grant(id);
        wait_done(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_int({tag, "_ctrl_outputs"},
                  int'({req_ready, resp_valid, resp_err, kx_start, core_start, core_kx_done}), 0);
        check_int({tag, "_resp_id"}, int'(resp_id), 0);
        check({tag, "_resp_data"}, resp_data, '0);
        check({tag, "_kx_key"}, kx_key, '0);
        check({tag, "_core_data_in"}, core_data_in, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench stopped by time limit");
    end

    initial begin
        int kx0;
        int n;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [1:0] got;
        logic [ID_W-1:0] hold_id;
        logic [127:0] hold_data;
        logic hold_err, stable, held, no_ready;

        reset = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            data_slot[i] = '0;
            key_slot[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single FIPS-197 job from requester 0, cold cache.
        kx0 = kx_starts;
        issue(2'd0, FIPS_PT, FIPS_KEY, 1'b0, "t1");
        check_int("t1_kx_count", kx_starts - kx0, 1);
        check_int("t1_kx_start_latency", kx_start_cycle - grant_cycle, 1);
        check_int("t1_core_after_kx_done", core_start_cycle - kx_done_cycle, 1);

        // 2: same key twice from requester 1; second job hits the cache.
        issue(2'd1, 128'h0123456789abcdef0011223344556677, KEY2, 1'b0, "t2a");
        kx0 = kx_starts;
        issue(2'd1, 128'hfedcba98765432100f0e0d0c0b0a0908, KEY2, 1'b0, "t2b");
        check_int("t2_hit_kx_count", kx_starts - kx0, 0);
        check_int("t2_hit_core_start_latency", core_start_cycle - grant_cycle, 1);
        check_int("t2_resp_after_core_done", resp_cycle - core_done_cycle, 1);

        // 3: all four requesters valid out of reset -> grants 0,1,2,3,0.
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            data_slot[i] = {4{32'(32'h1000 + i)}};
            key_slot[i]  = {4{32'(32'ha0000000 + i)}};
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            push_exp(2'(order[k]), data_slot[order[k]], key_slot[order[k]], 1'b0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == '0 && n < 300);
            check_int($sformatf("t3_grant%0d_in_time", k), int'(n < 300), 1);
            got = '0;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) got = 2'(i);
            check_int($sformatf("t3_grant%0d_order", k), int'(got), order[k]);
            check_int($sformatf("t3_grant%0d_outstanding", k), sb.size(), 5 - k);
            @(negedge clk);
        end
        req_valid = '0;
        wait_done("t3");

        // 4: core never finishes -> error response after TIMEOUT wait cycles.
        core_hang = 1'b1;
        issue(2'd2, 128'h44444444333333332222222211111111, KEY4, 1'b1, "t4a");
        check_int("t4_timeout_latency", resp_cycle - core_start_cycle, TIMEOUT + 1);
        core_hang = 1'b0;
        kx0 = kx_starts;
        issue(2'd2, 128'h9999999988888888777777776666666f, KEY4, 1'b0, "t4b");
        check_int("t4_reexpand_after_timeout", kx_starts - kx0, 1);

        // 5: consumer stalls 20 cycles; response holds, no new grant.
        resp_ready = 1'b0;
        start_req(2'd3, 128'h31415926535897932384626433832795, KEY6, 1'b0);
        wait_grant(2'd3);
        start_req(2'd0, 128'h27182818284590452353602874713527, KEYA, 1'b0);
        n = 0;
        while (!resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_int("t5_resp_in_time", int'(n < 300), 1);
        hold_id = resp_id;
        hold_data = resp_data;
        hold_err = resp_err;
        stable = 1'b1;
        held = 1'b1;
        no_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (resp_id !== hold_id || resp_data !== hold_data || resp_err !== hold_err) stable = 1'b0;
            if (resp_valid !== 1'b1) held = 1'b0;
            if (req_ready !== '0) no_ready = 1'b0;
        end
        check_int("t5_payload_stable", int'(stable), 1);
        check_int("t5_valid_held", int'(held), 1);
        check_int("t5_no_grant_while_stalled", int'(no_ready), 1);
        resp_ready = 1'b1;
        wait_grant(2'd0);
        wait_done("t5");

        // 6: reset during KX_WAIT drops the job; flush in CORE_WAIT waits for IDLE.
        start_req(2'd1, 128'h0badc0de0badc0de0badc0de0badc0de, KEY7, 1'b0);
        wait_grant(2'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("t6_midjob_reset");
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        kx0 = kx_starts;
        issue(2'd1, 128'h0badc0de0badc0de0badc0de0badc0de, KEY7, 1'b0, "t6a");
        check_int("t6_reissue_kx_count", kx_starts - kx0, 1);

        kx0 = kx_starts;
        start_req(2'd2, 128'h5555aaaa5555aaaa5555aaaa5555aaaa, KEY7, 1'b0);
        wait_grant(2'd2);
        n = 0;
        while (!core_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_int("t6_hit_core_start_seen", int'(core_start), 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_done("t6b");
        check_int("t6_hit_kx_count", kx_starts - kx0, 0);

        kx0 = kx_starts;
        issue(2'd3, 128'hcafef00dcafef00dcafef00dcafef00d, KEY7, 1'b0, "t6c");
        check_int("t6_flush_forces_reexpand", kx_starts - kx0, 1);

        check_int("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
